// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the 4-entry cache controller: FSM state encoding,
// entry count, LRU counter width/maximum and a saturating-decrement helper.
// Build option: CACHE_WRITEBACK_EN (consumed by cache_ctrl, not by this package).
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int NUM_ENTRIES = 4;
  localparam int CNT_WIDTH   = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL,
    ST_MWR,
    ST_RESP
  } state_t;

  // Decrement that sticks at zero so an old entry never wraps to "newest".
  function automatic logic [CNT_WIDTH-1:0] sat_dec(input logic [CNT_WIDTH-1:0] c);
    return (c == '0) ? c : c - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/cache_ctrl_lru_update.sv
// -----------------------------------------------------------------------------
// lru_update
// Combinational next-state for the per-entry LRU counters.
// Ports:
//   cnt      in   packed counters, entry i in slice i
//   sel      in   entry being accessed (becomes CNT_MAX)
//   dec      in   per-entry decrement mask (ignored for sel)
//   en       in   apply the update; counters hold when low
//   cnt_next out  updated counters
// Build option: none (CACHE_WRITEBACK_EN does not affect this block).
// -----------------------------------------------------------------------------
module lru_update
  import cache_pkg::*;
(
  input  logic [NUM_ENTRIES*CNT_WIDTH-1:0] cnt,
  input  logic [1:0]                       sel,
  input  logic [NUM_ENTRIES-1:0]           dec,
  input  logic                             en,
  output logic [NUM_ENTRIES*CNT_WIDTH-1:0] cnt_next
);

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cur;
    logic [CNT_WIDTH-1:0] nxt;

    assign cur = cnt[gi*CNT_WIDTH +: CNT_WIDTH];

    always_comb begin
      nxt = cur;
      if (en) begin
        if (sel == 2'(gi)) begin
          nxt = CNT_MAX;
        end else if (dec[gi]) begin
          nxt = sat_dec(cur);
        end
      end
    end

    assign cnt_next[gi*CNT_WIDTH +: CNT_WIDTH] = nxt;
  end

endmodule

// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
// Four-entry fully associative cache controller with external hit/victim
// lookup, 2-bit LRU counters and a single outstanding CPU request.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/we/addr/wdata       CPU request, accepted when req_ready
//   req_ready                     high only in IDLE
//   rsp_valid/rsp_rdata           one-cycle completion, read data or write echo
//   lookup_addr                   latched request address for the lookup logic
//   entry_addrs/cnt/valid         entry tags, LRU counters, valid bits
//   hit/sel/dec                   lookup result (hit, entry index, dec mask)
//   mem_req/we/addr/wdata         backing-memory request, stable until mem_ack
//   mem_ack/mem_rdata             memory completion and read data
// Build option: CACHE_WRITEBACK_EN selects write-back with dirty bits;
// undefined gives write-through, where every write goes through MWR.
// -----------------------------------------------------------------------------
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  input  logic                             req_we,
  input  logic [A_WIDTH-1:0]               req_addr,
  input  logic [D_WIDTH-1:0]               req_wdata,
  output logic                             req_ready,
  output logic                             rsp_valid,
  output logic [D_WIDTH-1:0]               rsp_rdata,
  output logic [A_WIDTH-1:0]               lookup_addr,
  output logic [NUM_ENTRIES*A_WIDTH-1:0]   entry_addrs,
  output logic [NUM_ENTRIES*CNT_WIDTH-1:0] cnt,
  output logic [NUM_ENTRIES-1:0]           valid,
  input  logic                             hit,
  input  logic [1:0]                       sel,
  input  logic [NUM_ENTRIES-1:0]           dec,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [A_WIDTH-1:0]               mem_addr,
  output logic [D_WIDTH-1:0]               mem_wdata,
  input  logic                             mem_ack,
  input  logic [D_WIDTH-1:0]               mem_rdata
);

  state_t state_reg, state_next;
  state_t done_state;

  logic [A_WIDTH-1:0]               addr_reg;
  logic                             we_reg;
  logic [D_WIDTH-1:0]               wdata_reg;
  logic [1:0]                       sel_reg;
  logic [NUM_ENTRIES-1:0]           dec_reg;
  logic [D_WIDTH-1:0]               rsp_rdata_reg;
  logic [NUM_ENTRIES*CNT_WIDTH-1:0] cnt_reg, cnt_next;

  logic [A_WIDTH-1:0]     tag_arr  [NUM_ENTRIES];
  logic [D_WIDTH-1:0]     data_arr [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_vec;

  logic               hit_access;
  logic               fill_done;
  logic               wr_en;
  logic [1:0]         wr_idx;
  logic [D_WIDTH-1:0] wr_data;
  logic               wb_needed;

  // An entry is touched either by a lookup hit or by completion of a fill.
  assign hit_access = (state_reg == ST_LOOKUP) && hit;
  assign fill_done  = (state_reg == ST_FILL) && mem_ack;
  assign wr_en      = (hit_access && we_reg) || fill_done;
  assign wr_idx     = fill_done ? sel_reg : sel;
  // On a write miss the filled line is immediately overwritten by the CPU data.
  assign wr_data    = we_reg ? wdata_reg : mem_rdata;

`ifdef CACHE_WRITEBACK_EN
  logic [NUM_ENTRIES-1:0] dirty_vec;
  assign wb_needed  = valid_vec[sel] && dirty_vec[sel];
  assign done_state = ST_RESP;
`else
  assign wb_needed  = 1'b0;
  assign done_state = we_reg ? ST_MWR : ST_RESP;
`endif

  // ---------------------------------------------------------------------------
  // Entry storage: one register set per entry, single shared write port
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    logic [A_WIDTH-1:0] tag_reg;
    logic [D_WIDTH-1:0] data_reg;
    logic               valid_reg;
    logic               wr_sel;

    assign wr_sel = wr_en && (wr_idx == 2'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_reg   <= '0;
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else if (wr_sel) begin
        data_reg <= wr_data;
        if (fill_done) begin
          tag_reg   <= addr_reg;
          valid_reg <= 1'b1;
        end
      end
    end

`ifdef CACHE_WRITEBACK_EN
    logic dirty_reg;
    // A write (hit or write-miss fill) leaves the line dirty; a read fill cleans it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dirty_reg <= 1'b0;
      end else if (wr_sel) begin
        dirty_reg <= we_reg;
      end
    end
    assign dirty_vec[gi] = dirty_reg;
`endif

    assign tag_arr[gi]                        = tag_reg;
    assign data_arr[gi]                       = data_reg;
    assign valid_vec[gi]                      = valid_reg;
    assign entry_addrs[gi*A_WIDTH +: A_WIDTH] = tag_reg;
  end

  // ---------------------------------------------------------------------------
  // LRU counters
  // ---------------------------------------------------------------------------
  lru_update u_lru_update (
    .cnt      (cnt_reg),
    .sel      (wr_idx),
    .dec      (fill_done ? dec_reg : dec),
    .en       (hit_access || fill_done),
    .cnt_next (cnt_next)
  );

  // ---------------------------------------------------------------------------
  // Request latches, lookup result latch, response data, counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      sel_reg       <= '0;
      dec_reg       <= '0;
      rsp_rdata_reg <= '0;
      cnt_reg       <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && req_valid) begin
        addr_reg  <= req_addr;
        we_reg    <= req_we;
        wdata_reg <= req_wdata;
      end
      if (state_reg == ST_LOOKUP) begin
        sel_reg <= sel;
        dec_reg <= dec;
      end
      if (hit_access) begin
        rsp_rdata_reg <= we_reg ? wdata_reg : data_arr[sel];
      end else if (fill_done) begin
        rsp_rdata_reg <= wr_data;
      end
      cnt_reg <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Memory outputs are decoded from the state register so that an
  // asynchronous reset removes mem_req without waiting for a clock edge.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_reg;
    mem_wdata  = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit)            state_next = done_state;
        else if (wb_needed) state_next = ST_WB;
        else                state_next = ST_FILL;
      end
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = tag_arr[sel_reg];
        mem_wdata = data_arr[sel_reg];
        if (mem_ack) state_next = ST_FILL;
      end
      ST_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = done_state;
      end
      ST_MWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rsp_rdata   = rsp_rdata_reg;
  assign lookup_addr = addr_reg;
  assign cnt         = cnt_reg;
  assign valid       = valid_vec;

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
// Directed scoreboard bench for cache_ctrl: a lookup model and a memory model
// form the environment, requests push expected read data into a queue and a
// monitor pops it on every rsp_valid. Honors CACHE_WRITEBACK_EN.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [7:0]  req_addr, req_wdata;
  logic        req_ready, rsp_valid;
  logic [7:0]  rsp_rdata, lookup_addr;
  logic [31:0] entry_addrs;
  logic [7:0]  cnt;
  logic [3:0]  valid;
  logic        lk_hit;
  logic [1:0]  lk_sel;
  logic [3:0]  lk_dec;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr, mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [256];
  logic [16:0] mem_log [$];
  int          mem_reads = 0;
  int          mem_writes = 0;
  int          mem_lat = 1;
  logic        mem_hold = 1'b0;
  logic        late_ack = 1'b0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  cache_ctrl #(.D_WIDTH(8), .A_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .lookup_addr (lookup_addr),
    .entry_addrs (entry_addrs),
    .cnt         (cnt),
    .valid       (valid),
    .hit         (lk_hit),
    .sel         (lk_sel),
    .dec         (lk_dec),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  // Lookup environment: hit on matching valid tag; otherwise victim is the
  // lowest-index invalid entry, else the lowest-index entry with minimum count.
  // Every other valid entry is marked for decrement.
  always_comb begin
    int best;
    int k;
    lk_hit = 1'b0;
    lk_sel = 2'd0;
    lk_dec = 4'd0;
    best   = 4;
    k      = 0;
    for (int i = 3; i >= 0; i--) begin
      if (valid[i] && entry_addrs[i*8 +: 8] == lookup_addr) begin
        lk_hit = 1'b1;
        lk_sel = 2'(i);
      end
    end
    if (!lk_hit) begin
      for (int i = 3; i >= 0; i--) begin
        k = valid[i] ? int'(cnt[i*2 +: 2]) : -1;
        if (k <= best) begin
          best   = k;
          lk_sel = 2'(i);
        end
      end
    end
    lk_dec = valid & ~(4'b0001 << lk_sel);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] log_at(input int idx);
    if (idx < 0 || idx >= mem_log.size()) return 17'hx;
    return mem_log[idx];
  endfunction

  // Memory model: acks after mem_lat waiting cycles, checks the request is
  // held stable while waiting, logs every transaction as {we, addr, data}.
  initial begin
    int wait_cnt;
    logic       cap_we;
    logic [7:0] cap_addr, cap_wdata;
    wait_cnt  = 0;
    cap_we    = 1'b0;
    cap_addr  = 8'd0;
    cap_wdata = 8'd0;
    mem_ack   = 1'b0;
    mem_rdata = 8'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (late_ack) begin
        mem_ack  = 1'b1;
        late_ack = 1'b0;
      end else if (rst_n && mem_req) begin
        if (wait_cnt == 0) begin
          cap_we    = mem_we;
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
        end else begin
          chk("mem_stable", {mem_we, mem_addr, mem_wdata}, {cap_we, cap_addr, cap_wdata});
          chk("busy_not_ready", 32'(req_ready), 32'd0);
        end
        wait_cnt++;
        if (!mem_hold && wait_cnt > mem_lat) begin
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            mem_writes++;
          end else begin
            mem_rdata = mem[mem_addr];
            mem_reads++;
          end
          mem_log.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem[mem_addr]});
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_rdata), 32'hx);
        end else begin
          e = exp_q.pop_front();
          $display("rsp rdata=0x%02h expected=0x%02h", rsp_rdata, e);
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e));
        end
      end
    end
  end

  // Issue one request from a negedge; lat counts negedges from acceptance
  // until rsp_valid is seen.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp, input logic wait_rsp, output int lat);
    int n;
    n = 0;
    lat = -1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (wait_rsp) exp_q.push_back(exp);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    if (!wait_rsp) return;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'd0;
    req_wdata = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    mem[8'h10] = 8'hA5;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_lookup_addr", 32'(lookup_addr), 32'd0);
    chk("rst_entry_addrs", entry_addrs, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss on 0x10.
    do_req(1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, lat);
    chk("fill_valid", 32'(valid), 32'h1);
    chk("fill_cnt", 32'(cnt), 32'h03);
    chk("fill_reads", 32'(mem_reads), 32'd1);
    chk("fill_no_wb", 32'(mem_writes), 32'd0);

    // Repeat read hits with two-cycle latency and no memory traffic.
    do_req(1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, lat);
    chk("hit_latency", 32'(lat), 32'd2);
    chk("hit_no_mem", 32'(mem_reads), 32'd1);

    // Fill the remaining entries, then age and evict.
    do_req(1'b0, 8'h20, 8'h00, 8'h21, 1'b1, lat);
    do_req(1'b0, 8'h30, 8'h00, 8'h31, 1'b1, lat);
    do_req(1'b0, 8'h40, 8'h00, 8'h41, 1'b1, lat);
    chk("full_cnt", 32'(cnt), 32'hE4);
    chk("full_valid", 32'(valid), 32'hF);
    do_req(1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, lat);
    chk("rehit_cnt", 32'(cnt), 32'h93);
    do_req(1'b0, 8'h50, 8'h00, 8'h51, 1'b1, lat);
    chk("evict_cnt", 32'(cnt), 32'h4E);
    chk("evict_tags", entry_addrs, 32'h40305010);
    do_req(1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, lat);
    chk("saturate_cnt", 32'(cnt), 32'h0B);

    // Write miss 0x20 = 0x3C (victim entry 2), then read it back.
    do_req(1'b1, 8'h20, 8'h3C, 8'h3C, 1'b1, lat);
    chk("wr_cnt", 32'(cnt), 32'h36);
`ifdef CACHE_WRITEBACK_EN
    chk("wr_no_memwrite", 32'(mem_writes), 32'd0);
`else
    chk("wr_through_cnt", 32'(mem_writes), 32'd1);
    chk("wr_through_txn", 32'(log_at(mem_log.size() - 1)), 32'h1203C);
`endif
    do_req(1'b0, 8'h20, 8'h00, 8'h3C, 1'b1, lat);
    chk("wr_hit_latency", 32'(lat), 32'd2);
    chk("wr_hit_cnt", 32'(cnt), 32'h31);

    // Age entry 2 out of the cache.
    do_req(1'b0, 8'h60, 8'h00, 8'h61, 1'b1, lat);
    do_req(1'b0, 8'h70, 8'h00, 8'h71, 1'b1, lat);
    do_req(1'b0, 8'h80, 8'h00, 8'h81, 1'b1, lat);
    do_req(1'b0, 8'h90, 8'h00, 8'h91, 1'b1, lat);
    chk("age_cnt", 32'(cnt), 32'hB1);
    chk("age_tags", entry_addrs, 32'h80906070);
    chk("age_writes", 32'(mem_writes), 32'd1);
`ifdef CACHE_WRITEBACK_EN
    chk("wb_txn", 32'(log_at(mem_log.size() - 2)), 32'h1203C);
`endif
    chk("last_fill_txn", 32'(log_at(mem_log.size() - 1)), 32'h09091);

    // Slow memory: request must hold for 20+ cycles.
    mem_lat = 20;
    do_req(1'b0, 8'hA0, 8'h00, 8'hA1, 1'b1, lat);
    chk("slow_latency_gt20", 32'(lat > 20), 32'd1);
    chk("slow_cnt", 32'(cnt), 32'h6C);
    mem_lat = 1;

    // Reset in the middle of a fill.
    mem_hold = 1'b1;
    do_req(1'b0, 8'hB0, 8'h00, 8'h00, 1'b0, lat);
    n = 0;
    while (!(mem_req && !mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fill_started", 32'(mem_req && !mem_we), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_mem_req", 32'(mem_req), 32'd0);
    chk("rst_drop_valid", 32'(valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    mem_hold = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_cnt", 32'(cnt), 32'd0);
    late_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("late_ack_ready", 32'(req_ready), 32'd1);
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    chk("late_ack_valid", 32'(valid), 32'd0);

    // Cache works again after the abandoned transaction.
    do_req(1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, lat);
    chk("refill_valid", 32'(valid), 32'h1);
    chk("refill_cnt", 32'(cnt), 32'h03);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
